// File: rtl/morra_scoreboard_if.sv
// Signal bundle between a MorraCinese game engine (master side) and its match scoreboard.
interface morra_scoreboard_if;
    logic       START;
    logic [1:0] ROUND;
    logic [1:0] GAME;
    logic [3:0] WINS1;
    logic [3:0] WINS2;
    logic [3:0] DRAWS;
    logic [4:0] RCOUNT;
    logic [4:0] ICOUNT;
    logic       GAME_EVT;
    logic       MATCH_OVER;
    logic [1:0] MATCH_WIN;

    modport master (
        output START, ROUND, GAME,
        input  WINS1, WINS2, DRAWS, RCOUNT, ICOUNT, GAME_EVT, MATCH_OVER, MATCH_WIN
    );

    modport slave (
        input  START, ROUND, GAME,
        output WINS1, WINS2, DRAWS, RCOUNT, ICOUNT, GAME_EVT, MATCH_OVER, MATCH_WIN
    );
endinterface

// File: rtl/morra_scoreboard.sv
// Match scoreboard for MorraCinese: tallies rounds per game and games per match,
// declaring a match winner once a player reaches MATCH_TARGET game wins.
module morra_scoreboard #(
    parameter int unsigned MATCH_TARGET = 3
) (
    input  logic               clk,
    input  logic               RST_N,
    morra_scoreboard_if.slave  bus
);
    localparam int unsigned WW = 4;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PLAYING    = 2'd1,
        MATCH_DONE = 2'd2
    } state_t;

    state_t          state_q, state_n;
    logic [WW-1:0]   wins1_q, wins1_n;
    logic [WW-1:0]   wins2_q, wins2_n;
    logic [WW-1:0]   draws_q, draws_n;
    logic [CW-1:0]   rcount_q, rcount_n;
    logic [CW-1:0]   icount_q, icount_n;
    logic            game_evt_q, game_evt_n;
    logic            match_over_q, match_over_n;
    logic [1:0]      match_win_q, match_win_n;

    function automatic logic [CW-1:0] sat_inc5(input logic [CW-1:0] v);
        return (v == '1) ? v : v + CW'(1);
    endfunction

    function automatic logic [WW-1:0] sat_inc4(input logic [WW-1:0] v);
        return (v == '1) ? v : v + WW'(1);
    endfunction

    // State and output registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            wins1_q      <= '0;
            wins2_q      <= '0;
            draws_q      <= '0;
            rcount_q     <= '0;
            icount_q     <= '0;
            game_evt_q   <= 1'b0;
            match_over_q <= 1'b0;
            match_win_q  <= 2'b00;
        end else begin
            state_q      <= state_n;
            wins1_q      <= wins1_n;
            wins2_q      <= wins2_n;
            draws_q      <= draws_n;
            rcount_q     <= rcount_n;
            icount_q     <= icount_n;
            game_evt_q   <= game_evt_n;
            match_over_q <= match_over_n;
            match_win_q  <= match_win_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n     = state_q;
        wins1_n     = wins1_q;
        wins2_n     = wins2_q;
        draws_n     = draws_q;
        rcount_n    = rcount_q;
        icount_n    = icount_q;
        game_evt_n  = 1'b0;
        match_win_n = match_win_q;

        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    rcount_n = '0;
                    icount_n = '0;
                    state_n  = PLAYING;
                end
            end
            PLAYING: begin
                if (bus.START) begin
                    rcount_n = '0;
                    icount_n = '0;
                end else if (bus.GAME == 2'b00) begin
                    if (bus.ROUND != 2'b00) rcount_n = sat_inc5(rcount_q);
                    else                    icount_n = sat_inc5(icount_q);
                end else begin
                    game_evt_n = 1'b1;
                    case (bus.GAME)
                        2'b01:   wins1_n = wins1_q + WW'(1);
                        2'b10:   wins2_n = wins2_q + WW'(1);
                        2'b11:   draws_n = sat_inc4(draws_q);
                        default: ;
                    endcase
                    if (wins1_n == WW'(MATCH_TARGET)) begin
                        state_n     = MATCH_DONE;
                        match_win_n = 2'b01;
                    end else if (wins2_n == WW'(MATCH_TARGET)) begin
                        state_n     = MATCH_DONE;
                        match_win_n = 2'b10;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            MATCH_DONE: begin
                if (bus.START) begin
                    wins1_n     = '0;
                    wins2_n     = '0;
                    draws_n     = '0;
                    rcount_n    = '0;
                    icount_n    = '0;
                    match_win_n = 2'b00;
                    state_n     = PLAYING;
                end
            end
            default: state_n = IDLE;
        endcase

        match_over_n = (state_n == MATCH_DONE);
    end

    assign bus.WINS1      = wins1_q;
    assign bus.WINS2      = wins2_q;
    assign bus.DRAWS      = draws_q;
    assign bus.RCOUNT     = rcount_q;
    assign bus.ICOUNT     = icount_q;
    assign bus.GAME_EVT   = game_evt_q;
    assign bus.MATCH_OVER = match_over_q;
    assign bus.MATCH_WIN  = match_win_q;
endmodule

// File: tb/tb_morra_scoreboard.sv
// Directed-vector bench for morra_scoreboard; expectations queued by the driver, checked by a monitor.
module tb_morra_scoreboard;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    morra_scoreboard_if ifa ();
    morra_scoreboard_if ifb ();

    morra_scoreboard #(.MATCH_TARGET(3))  dut_a (.clk(clk), .RST_N(rst_n), .bus(ifa.slave));
    morra_scoreboard #(.MATCH_TARGET(15)) dut_b (.clk(clk), .RST_N(rst_n), .bus(ifb.slave));

    typedef struct {
        int          step;
        bit          sel;
        logic [25:0] outv;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step   = 0;
    bit   sel    = 1'b0;

    // Apply one cycle of inputs to both DUTs and queue the expected outputs of the selected one.
    task automatic cy(input logic r, input logic s, input logic [1:0] rd, input logic [1:0] gm,
                      input logic [3:0] w1, input logic [3:0] w2, input logic [3:0] dr,
                      input logic [4:0] rc, input logic [4:0] ic,
                      input logic ev, input logic ov, input logic [1:0] mw);
        exp_t e;
        rst_n     = r;
        ifa.START = s;  ifa.ROUND = rd;  ifa.GAME = gm;
        ifb.START = s;  ifb.ROUND = rd;  ifb.GAME = gm;
        @(posedge clk);
        step++;
        e.step = step;
        e.sel  = sel;
        e.outv = {w1, w2, dr, rc, ic, ev, ov, mw};
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: outputs are compared every cycle, away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t        e;
            logic [25:0] act;
            e   = exp_q.pop_front();
            act = e.sel ? {ifb.WINS1, ifb.WINS2, ifb.DRAWS, ifb.RCOUNT, ifb.ICOUNT,
                           ifb.GAME_EVT, ifb.MATCH_OVER, ifb.MATCH_WIN}
                        : {ifa.WINS1, ifa.WINS2, ifa.DRAWS, ifa.RCOUNT, ifa.ICOUNT,
                           ifa.GAME_EVT, ifa.MATCH_OVER, ifa.MATCH_WIN};
            checks++;
            if (act !== e.outv) begin
                errors++;
                $display("FAIL step%0d dut%s: got w1=%0d w2=%0d dr=%0d rc=%0d ic=%0d evt=%b over=%b win=%b, want w1=%0d w2=%0d dr=%0d rc=%0d ic=%0d evt=%b over=%b win=%b",
                         e.step, e.sel ? "B" : "A",
                         act[25:22], act[21:18], act[17:14], act[13:9], act[8:4], act[3], act[2], act[1:0],
                         e.outv[25:22], e.outv[21:18], e.outv[17:14], e.outv[13:9], e.outv[8:4],
                         e.outv[3], e.outv[2], e.outv[1:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //  r  s  rd     gm     w1 w2 dr rc ic ev ov mw
        sel = 1'b0;
        cy(0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        cy(0, 1, 2'b01, 2'b01, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        cy(1, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        cy(1, 0, 2'b01, 2'b00, 0, 0, 0, 1, 0, 0, 0, 2'b00);
        cy(1, 0, 2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0, 2'b00);
        cy(1, 0, 2'b10, 2'b00, 0, 0, 0, 2, 1, 0, 0, 2'b00);
        cy(1, 0, 2'b11, 2'b00, 0, 0, 0, 3, 1, 0, 0, 2'b00);
        cy(1, 0, 2'b01, 2'b01, 1, 0, 0, 3, 1, 1, 0, 2'b00);
        cy(1, 0, 2'b01, 2'b01, 1, 0, 0, 3, 1, 0, 0, 2'b00);
        cy(1, 1, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b00);
        cy(1, 0, 2'b10, 2'b00, 1, 0, 0, 1, 0, 0, 0, 2'b00);
        cy(1, 0, 2'b10, 2'b10, 1, 1, 0, 1, 0, 1, 0, 2'b00);
        cy(1, 1, 2'b00, 2'b00, 1, 1, 0, 0, 0, 0, 0, 2'b00);
        cy(1, 0, 2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0, 2'b00);
        cy(1, 0, 2'b11, 2'b11, 1, 1, 1, 0, 1, 1, 0, 2'b00);
        cy(1, 1, 2'b00, 2'b00, 1, 1, 1, 0, 0, 0, 0, 2'b00);
        cy(1, 0, 2'b01, 2'b01, 2, 1, 1, 0, 0, 1, 0, 2'b00);
        cy(1, 1, 2'b00, 2'b00, 2, 1, 1, 0, 0, 0, 0, 2'b00);
        cy(1, 0, 2'b01, 2'b00, 2, 1, 1, 1, 0, 0, 0, 2'b00);
        // START together with a game result: abort wins, nothing recorded.
        cy(1, 1, 2'b01, 2'b10, 2, 1, 1, 0, 0, 0, 0, 2'b00);
        cy(1, 0, 2'b01, 2'b00, 2, 1, 1, 1, 0, 0, 0, 2'b00);
        cy(1, 0, 2'b11, 2'b01, 3, 1, 1, 1, 0, 1, 1, 2'b01);
        cy(1, 0, 2'b01, 2'b10, 3, 1, 1, 1, 0, 0, 1, 2'b01);
        cy(1, 0, 2'b00, 2'b01, 3, 1, 1, 1, 0, 0, 1, 2'b01);
        cy(0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        // Rebuild a P1 match win, then start a new match from MATCH_DONE.
        cy(1, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        cy(1, 0, 2'b01, 2'b01, 1, 0, 0, 0, 0, 1, 0, 2'b00);
        cy(1, 1, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b00);
        cy(1, 0, 2'b01, 2'b01, 2, 0, 0, 0, 0, 1, 0, 2'b00);
        cy(1, 1, 2'b00, 2'b00, 2, 0, 0, 0, 0, 0, 0, 2'b00);
        cy(1, 0, 2'b01, 2'b01, 3, 0, 0, 0, 0, 1, 1, 2'b01);
        cy(1, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        cy(1, 0, 2'b01, 2'b00, 0, 0, 0, 1, 0, 0, 0, 2'b00);
        cy(1, 0, 2'b10, 2'b10, 0, 1, 0, 1, 0, 1, 0, 2'b00);
        cy(1, 1, 2'b00, 2'b00, 0, 1, 0, 0, 0, 0, 0, 2'b00);
        cy(1, 0, 2'b10, 2'b10, 0, 2, 0, 0, 0, 1, 0, 2'b00);
        cy(1, 1, 2'b00, 2'b00, 0, 2, 0, 0, 0, 0, 0, 2'b00);
        cy(1, 0, 2'b10, 2'b10, 0, 3, 0, 0, 0, 1, 1, 2'b10);
        cy(1, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        cy(1, 0, 2'b01, 2'b00, 0, 0, 0, 1, 0, 0, 0, 2'b00);
        // Mid-game reset, held for two cycles, then IDLE ignores a game result.
        cy(0, 1, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        cy(0, 0, 2'b01, 2'b01, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        cy(1, 0, 2'b01, 2'b01, 0, 0, 0, 0, 0, 0, 0, 2'b00);

        // Saturation checks on the MATCH_TARGET=15 instance.
        sel = 1'b1;
        cy(0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        cy(1, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        for (int i = 0; i < 40; i++)
            cy(1, 0, 2'b01, 2'b00, 0, 0, 0, 5'((i + 1 > 31) ? 31 : i + 1), 0, 0, 0, 2'b00);
        for (int i = 0; i < 40; i++)
            cy(1, 0, 2'b00, 2'b00, 0, 0, 0, 31, 5'((i + 1 > 31) ? 31 : i + 1), 0, 0, 2'b00);
        cy(1, 0, 2'b11, 2'b11, 0, 0, 1, 31, 31, 1, 0, 2'b00);
        for (int k = 1; k <= 15; k++) begin
            cy(1, 1, 2'b00, 2'b00, 0, 0, 4'(k), 0, 0, 0, 0, 2'b00);
            cy(1, 0, 2'b11, 2'b11, 0, 0, 4'((k + 1 > 15) ? 15 : k + 1), 0, 0, 1, 0, 2'b00);
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
